// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Op encodings follow funct3 directly.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } muldiv_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Signed (W+1)x(W+1) multiplier, product delayed by MUL_STAGES registers.
// Only the low 2W product bits are ever needed, so the math is done at 2W.
module mul_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_WIDTH:0] a,
    input  logic signed [DATA_WIDTH:0] b,
    output logic [2*DATA_WIDTH-1:0]   prod
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    logic [PW-1:0]        stg [MUL_STAGES];

    assign ax = {{(PW-DATA_WIDTH-1){a[DATA_WIDTH]}}, a};
    assign bx = {{(PW-DATA_WIDTH-1){b[DATA_WIDTH]}}, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) stg[i] <= '0;
        end else begin
            stg[0] <= ax * bx;
            for (int i = 1; i < MUL_STAGES; i++) stg[i] <= stg[i-1];
        end
    end

    assign prod = stg[MUL_STAGES-1];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier plus radix-2
// restoring divider, one operation in flight at a time.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [4:0]            RdIn,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic [4:0]            RdOut
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + MUL_STAGES) + 1;

    muldiv_state_e state, nxt;
    muldiv_op_e    opReg;

    logic [4:0]         rdLatch, rdOutReg;
    logic [W-1:0]       resReg, quo, rem, dvsr;
    logic [CW-1:0]      cnt;
    logic               busyReg, doneReg, resFromMul;
    logic               negQ, negR, accept;
    logic               signedOp, negA, negB, divZero, ovf, isSpecial;
    logic signed [W:0]  mulA, mulB;
    logic [2*W-1:0]     prod;
    logic [W-1:0]       mulSel, magA, magB, special, fixVal;
    logic [W:0]         trial;

    assign signedOp  = ~Op[0];
    assign negA      = signedOp & SrcA[W-1];
    assign negB      = signedOp & SrcB[W-1];
    assign magA      = negA ? -SrcA : SrcA;
    assign magB      = negB ? -SrcB : SrcB;
    assign divZero   = (SrcB == '0);
    assign ovf       = signedOp & (SrcA == {1'b1, {(W-1){1'b0}}}) & (&SrcB);
    assign isSpecial = divZero | ovf;
    assign special   = divZero ? (Op[1] ? SrcA : '1) : (Op[1] ? '0 : SrcA);

    assign mulA = {((Op == OP_MULH) | (Op == OP_MULHSU)) & SrcA[W-1], SrcA};
    assign mulB = {(Op == OP_MULH) & SrcB[W-1], SrcB};

    mul_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .MUL_STAGES(MUL_STAGES)
    ) uMul (
        .clk (clk),
        .rst (rst),
        .a   (mulA),
        .b   (mulB),
        .prod(prod)
    );

    assign mulSel = (opReg == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    assign trial  = {rem, quo[W-1]} - {1'b0, dvsr};
    assign fixVal = opReg[1] ? (negR ? -rem : rem) : (negQ ? -quo : quo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        if (Flush) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    nxt = S_IDLE;
                    if (Start) begin
                        accept = 1'b1;
                        if (!is_div(Op))
                            nxt = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                        else
                            nxt = isSpecial ? S_DONE : S_DIV;
                    end
                end
                S_MUL:   if (cnt == CW'(1)) nxt = S_DONE;
                S_DIV:   if (cnt == '0) nxt = S_FIX;
                S_FIX:   nxt = S_DONE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg      <= OP_MUL;
            rdLatch    <= '0;
            rdOutReg   <= '0;
            resReg     <= '0;
            quo        <= '0;
            rem        <= '0;
            dvsr       <= '0;
            cnt        <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            resFromMul <= 1'b0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
        end else begin
            busyReg    <= (nxt == S_MUL) | (nxt == S_DIV) | (nxt == S_FIX);
            doneReg    <= (nxt == S_DONE);
            resFromMul <= (nxt == S_DONE) &
                          ((state == S_MUL) | (accept & ~is_div(Op)));
            if (nxt == S_DONE) rdOutReg <= accept ? RdIn : rdLatch;
            // Freeze the visible product before the multiplier pipe moves on
            if (resFromMul) resReg <= mulSel;
            if (accept) begin
                opReg   <= muldiv_op_e'(Op);
                rdLatch <= RdIn;
                cnt     <= is_div(Op) ? CW'(W-1) : CW'(MUL_STAGES-1);
                quo     <= magA;
                rem     <= '0;
                dvsr    <= magB;
                negQ    <= negA ^ negB;
                negR    <= negA;
                if (is_div(Op) && isSpecial) resReg <= special;
            end else begin
                unique case (state)
                    S_MUL: cnt <= cnt - CW'(1);
                    S_DIV: begin
                        quo <= {quo[W-2:0], ~trial[W]};
                        rem <= trial[W] ? {rem[W-2:0], quo[W-1]} : trial[W-1:0];
                        cnt <= cnt - CW'(1);
                    end
                    S_FIX: if (nxt == S_DONE) resReg <= fixVal;
                    default: ;
                endcase
            end
        end
    end

    assign Busy   = busyReg;
    assign Done   = doneReg;
    assign Result = resFromMul ? mulSel : resReg;
    assign RdOut  = rdOutReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_WIDTH=32, MUL_STAGES=2).
// Expected values come from plain 64-bit arithmetic on the RV32M rules.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  RdIn;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  RdOut;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(
        .DATA_WIDTH(32),
        .MUL_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Op    (Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .RdIn  (RdIn),
        .Flush (Flush),
        .Busy  (Busy),
        .Done  (Done),
        .Result(Result),
        .RdOut (RdOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refResult(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to its Done pulse.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int          lat, busyN, expLat;
        logic [31:0] expRes, res;
        logic [4:0]  rdo;
        logic        busyAtDone;
        expRes = refResult(op, a, b);
        expLat = refLatency(op, a, b);
        lat = -1; busyN = 0; res = '0; rdo = '0; busyAtDone = 1'b1;
        Start = 1'b1; Op = op; SrcA = a; SrcB = b; RdIn = rd;
        step();
        Start = 1'b0;
        Op    = 3'($urandom);
        SrcA  = $urandom;
        SrcB  = $urandom;
        RdIn  = 5'($urandom);
        for (int n = 1; n <= 60; n++) begin
            if (Done) begin
                lat = n; res = Result; rdo = RdOut; busyAtDone = Busy;
                break;
            end
            if (Busy) busyN++;
            step();
        end
        check($sformatf("op%0d.lat", op), lat, expLat);
        check($sformatf("op%0d.res a=%h b=%h", op, a, b), res, expRes);
        check($sformatf("op%0d.rd", op), {27'b0, rdo}, {27'b0, rd});
        check($sformatf("op%0d.busyCycles", op), busyN, expLat - 1);
        check($sformatf("op%0d.busyAtDone", op), {31'b0, busyAtDone}, 0);
        step();
        check($sformatf("op%0d.donePulse", op), {31'b0, Done}, 0);
    endtask

    initial begin
        int          dn, doneCnt;
        int          dCyc [2];
        logic [31:0] dRes [2];
        logic [4:0]  dRd  [2];
        logic [31:0] held;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; Start = 1'b0; Flush = 1'b0;
        Op = '0; SrcA = '0; SrcB = '0; RdIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy",   {31'b0, Busy}, 0);
        check("rst.done",   {31'b0, Done}, 0);
        check("rst.result", Result, 0);
        check("rst.rdout",  {27'b0, RdOut}, 0);
        rst = 1'b0;
        step();

        runOp(3'd0, 32'hFFFF_FFFF, 32'h2, 5'd1);
        runOp(3'd1, 32'hFFFF_FFFF, 32'h2, 5'd2);
        runOp(3'd2, 32'hFFFF_FFFF, 32'h2, 5'd3);
        runOp(3'd3, 32'hFFFF_FFFF, 32'h2, 5'd4);
        runOp(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd5);
        runOp(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd6);
        runOp(3'd5, 32'd100, 32'd7, 5'd7);
        runOp(3'd5, 32'h1234_5678, 32'h0, 5'd8);
        runOp(3'd6, 32'd5, 32'h0, 5'd9);
        runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = $urandom_range(1, 15);
                3:       rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            runOp(rop, ra, rb, 5'($urandom));
        end

        // Flush in cycle 10 of a DIV
        held  = Result;
        Start = 1'b1; Op = 3'd4; SrcA = 32'hFFFF_FFF9; SrcB = 32'h2; RdIn = 5'd11;
        step();
        Start = 1'b0;
        repeat (9) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush.busy", {31'b0, Busy}, 0);
        doneCnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (Done) doneCnt++;
            step();
        end
        check("flush.noDone", doneCnt, 0);
        check("flush.hold", Result, held);
        runOp(3'd0, 32'd3, 32'd4, 5'd12);

        // Flush wins over a same-cycle Start
        Start = 1'b1; Flush = 1'b1; Op = 3'd5; SrcA = 32'd9; SrcB = 32'd3;
        step();
        Start = 1'b0; Flush = 1'b0;
        check("flushStart.busy", {31'b0, Busy}, 0);
        check("flushStart.done", {31'b0, Done}, 0);
        step();

        // Start held high through a DIVU; second op accepted in the DONE cycle
        dn = 0;
        for (int k = 0; k < 2; k++) begin
            dCyc[k] = -1; dRes[k] = '0; dRd[k] = '0;
        end
        Start = 1'b1; Op = 3'd5; SrcA = 32'd100; SrcB = 32'd7; RdIn = 5'd9;
        step();
        for (int n = 1; n <= 80; n++) begin
            if (n == 1) begin SrcA = 32'd200; RdIn = 5'd10; end
            if (n == 35) Start = 1'b0;
            if (Done) begin
                if (dn < 2) begin
                    dCyc[dn] = n; dRes[dn] = Result; dRd[dn] = RdOut;
                end
                dn++;
            end
            step();
        end
        Start = 1'b0;
        check("held.doneCount", dn, 2);
        check("held.cyc0", dCyc[0], 34);
        check("held.res0", dRes[0], 32'd14);
        check("held.rd0", {27'b0, dRd[0]}, 32'd9);
        check("held.cyc1", dCyc[1], 68);
        check("held.res1", dRes[1], 32'd28);
        check("held.rd1", {27'b0, dRd[1]}, 32'd10);

        // Reset in cycle 5 of an op
        runOp(3'd0, 32'd3, 32'd4, 5'd13);
        Start = 1'b1; Op = 3'd5; SrcA = 32'd100; SrcB = 32'd7; RdIn = 5'd14;
        step();
        Start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("midRst.busy",   {31'b0, Busy}, 0);
        check("midRst.done",   {31'b0, Done}, 0);
        check("midRst.result", Result, 0);
        check("midRst.rdout",  {27'b0, RdOut}, 0);
        step();
        rst = 1'b0;
        doneCnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (Done) doneCnt++;
            step();
        end
        check("midRst.noDone", doneCnt, 0);
        runOp(3'd7, 32'd100, 32'd7, 5'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised RV32M multiply/divide unit for the execute stage of the pipelined core. It accepts one operation at a time from the E stage. Multiplies run through a fixed-depth pipelined multiplier; divides and remainders run on a radix-2 iterative divider. A registered Busy drives the hazard unit's stall, and a one-cycle Done returns the result and destination register to the E/M pipeline register.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (even, ≥8)
- MUL_STAGES, 2, multiplier pipeline depth in cycles (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- Start  in  1  operation request, sampled only while Busy=0
- Op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  DATA_WIDTH  rs1 operand (dividend / multiplicand)
- SrcB  in  DATA_WIDTH  rs2 operand (divisor / multiplier)
- RdIn  in  5  destination register of the request
- Flush  in  1  abort any in-flight operation
- Busy  out  1  operation in progress; hazard unit stalls F/D/E while high
- Done  out  1  one-cycle result-valid pulse
- Result  out  DATA_WIDTH  result, valid while Done=1
- RdOut  out  5  destination register, valid while Done=1

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE with Start=1, Flush=0:
  - Latch Op, RdIn.
  - Mul ops go to MUL.
  - Div/rem ops go to DIV with operand magnitudes and result signs latched. The exceptions are divide-by-zero and signed overflow (SrcA = most negative, SrcB = −1), which go straight to DONE.
- MUL: down-counter from MUL_STAGES−1; at 0 go to DONE.
  - Result is the low DATA_WIDTH bits of the product for MUL, otherwise the high bits.
  - Operands are sign-extended per op: MULH both signed, MULHSU A signed/B unsigned, MULHU both unsigned.
- DIV: restoring shift-subtract, one quotient bit per cycle, DATA_WIDTH cycles, then FIX.
- FIX: negate quotient if operand signs differ (DIV only); negate remainder if dividend negative (REM only); go to DONE.
- Divide-by-zero: quotient = all ones, remainder = SrcA.
- Signed overflow: quotient = SrcA, remainder = 0.
- DONE: Done=1 for exactly one cycle. Without a new Start, go to IDLE. With a new Start, the back-to-back request is accepted.
- Start while Busy=1: ignored, no side effect.
- Flush (any state): next state IDLE, Done suppressed, Result/RdOut hold their old value. Flush has priority over a same-cycle Start, which is dropped.
- Arithmetic is done at width DATA_WIDTH+1 for the divider remainder and 2·DATA_WIDTH for the product. There is no other width growth.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, Result 0, RdOut 0, counters 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Let the Start cycle be cycle 0. Done is high in:
  - cycle MUL_STAGES for mul ops
  - cycle DATA_WIDTH+2 for normal div/rem
  - cycle 1 for div-by-zero/overflow
- Busy is high from cycle 1 until the cycle before Done, and low while Done=1.
- The hazard unit must also stall in cycle 0, using Start & ~Busy. This unit does not assert Busy combinationally.
- Throughput: one new op per (latency) cycles; there are no overlapping ops even though the multiplier is pipelined.
- rst mid-operation: immediate return to reset values. Any partial result is lost and no Done is issued.

## Structure
- Package muldiv_pkg:
  - muldiv_op_e enum, encoding the funct3 values above
  - muldiv_state_e enum, holding the five states
  - helper function is_div(op)
- Sub-module mul_pipe (DATA_WIDTH, MUL_STAGES):
  - (DATA_WIDTH+1)-bit signed × signed multiplier, retimed over MUL_STAGES registers
  - Reset per this spec; no handshake of its own
- The top FSM, the divider datapath and the FIX logic live in muldiv_unit.

## Test plan
- MUL/MULH/MULHU/MULHSU, DATA_WIDTH=32, MUL_STAGES=2: SrcA=0xFFFF_FFFF, SrcB=0x0000_0002. Required: Done in cycle 2 with 0xFFFF_FFFE / 0xFFFF_FFFF / 0x0000_0001 / 0xFFFF_FFFF respectively.
- DIV −7/2: Result 0xFFFF_FFFD. REM −7/2: Result 0xFFFF_FFFF. DIVU 100/7: Result 14. Each with Done in cycle 34, Busy high cycles 1–33, RdOut equal to RdIn.
- DIVU x/0 → 0xFFFF_FFFF. REM 5/0 → 5. DIV 0x8000_0000/−1 → 0x8000_0000. Each with Done in cycle 1.
- Flush in cycle 10 of a DIV: Busy low from cycle 11, and no Done for 40 cycles. A following MUL 3×4 → 12 completes normally.
- Start held high through a DIV: exactly one Done. The second op, accepted in the DONE cycle, produces its own Done after its own latency. Asserting rst in cycle 5 of any op clears all outputs immediately.
